// File: rtl/calc_pkg.sv
// Shared state and opcode encodings for the calculator controller and LED driver.
package calc_pkg;

    typedef enum logic [2:0] {
        S_INPUT_A = 3'd0,
        S_INPUT_B = 3'd1,
        S_RESULT  = 3'd2,
        S_CALC    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

endpackage

// File: rtl/calc_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses W cycles after start.
// Instantiated by calc_ctrl only when CALC_DIV_EN is defined.
module calc_divider #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, quo_q, div_q;
    logic [W-1:0]  rem_n, quo_n;
    logic [W:0]    trial;
    logic [CW-1:0] cnt;

    // The final step is exposed combinationally so the result is usable on the W-th edge.
    always_comb begin
        trial = {rem_q, quo_q[W-1]};
        rem_n = trial[W-1:0];
        quo_n = {quo_q[W-2:0], 1'b0};
        if (trial >= {1'b0, div_q}) begin
            rem_n = trial[W-1:0] - div_q;
            quo_n = {quo_q[W-2:0], 1'b1};
        end
    end

    assign done     = (cnt == CW'(1));
    assign quotient = quo_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt   <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
            cnt   <= CW'(W);
        end else if (cnt != '0) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt   <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencing FSM: operand capture, operator latch, arithmetic, result/error.
// Define CALC_DIV_EN to instantiate the divider; otherwise op 3 is an illegal operation.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    input  logic [1:0]   op_sel,
    input  logic         btn_ok,
    input  logic         btn_clr,
    output logic [2:0]   current_state,
    output logic [W-1:0] data_saved,
    output logic         err,
    output logic         busy
);

    state_t         state;
    op_t            op;
    logic [W-1:0]   a, b;
    logic           ok_q, clr_q;
    logic           ok_p, clr_p;
    logic [W-1:0]   sum, diff;
    logic           carry;
    logic [2*W-1:0] prod;

    assign ok_p          = btn_ok & ~ok_q;
    assign clr_p         = btn_clr & ~clr_q;
    assign current_state = state;

    assign {carry, sum} = {1'b0, a} + {1'b0, b};
    assign diff         = a - b;
    assign prod         = {{W{1'b0}}, a} * {{W{1'b0}}, b};

`ifdef CALC_DIV_EN
    logic         div_start, div_done;
    logic [W-1:0] div_quotient;

    // Start on the same edge that enters S_CALC so the divide occupies exactly W cycles.
    assign div_start = (state == S_INPUT_B) && ok_p && !clr_p &&
                       (op_t'(op_sel) == OP_DIV) && (sw != '0);

    calc_divider #(.W(W)) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (clr_p),
        .dividend (a),
        .divisor  (sw),
        .done     (div_done),
        .quotient (div_quotient)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INPUT_A;
            op         <= OP_ADD;
            a          <= '0;
            b          <= '0;
            data_saved <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            ok_q       <= 1'b1;
            clr_q      <= 1'b1;
        end else begin
            ok_q  <= btn_ok;
            clr_q <= btn_clr;
            if (clr_p) begin
                state      <= S_INPUT_A;
                data_saved <= '0;
                err        <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_INPUT_A: if (ok_p) begin
                        a          <= sw;
                        data_saved <= sw;
                        state      <= S_INPUT_B;
                    end
                    S_INPUT_B: if (ok_p) begin
                        b     <= sw;
                        op    <= op_t'(op_sel);
                        state <= S_CALC;
                        busy  <= 1'b1;
                    end
                    S_CALC: begin
                        case (op)
                            OP_ADD: begin
                                data_saved <= sum;
                                err        <= carry;
                                state      <= S_RESULT;
                                busy       <= 1'b0;
                            end
                            OP_SUB: begin
                                data_saved <= diff;
                                err        <= (a < b);
                                state      <= S_RESULT;
                                busy       <= 1'b0;
                            end
                            OP_MUL: begin
                                data_saved <= prod[W-1:0];
                                err        <= |prod[2*W-1:W];
                                state      <= S_RESULT;
                                busy       <= 1'b0;
                            end
                            OP_DIV: begin
`ifdef CALC_DIV_EN
                                if (b == '0) begin
                                    err   <= 1'b1;
                                    state <= S_ERROR;
                                    busy  <= 1'b0;
                                end else if (div_done) begin
                                    data_saved <= div_quotient;
                                    err        <= 1'b0;
                                    state      <= S_RESULT;
                                    busy       <= 1'b0;
                                end
`else
                                err   <= 1'b1;
                                state <= S_ERROR;
                                busy  <= 1'b0;
`endif
                            end
                            default: ;
                        endcase
                    end
                    S_RESULT: if (ok_p) begin
                        a     <= data_saved;
                        err   <= 1'b0;
                        state <= S_INPUT_B;
                    end
                    S_ERROR: if (ok_p) begin
                        data_saved <= '0;
                        err        <= 1'b0;
                        state      <= S_INPUT_A;
                    end
                    default: begin
                        state <= S_INPUT_A;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: directed table, corner sequences and random traffic
// against an arithmetic reference model. Honours CALC_DIV_EN like the design.
module tb_calc_ctrl;

    localparam int W = 8;
`ifdef CALC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int ST_A = 0, ST_B = 1, ST_RES = 2, ST_CALC = 3, ST_ERR = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw;
    logic [1:0]   op_sel;
    logic         btn_ok, btn_clr;
    logic [2:0]   current_state;
    logic [W-1:0] data_saved;
    logic         err, busy;

    calc_ctrl #(.W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw            (sw),
        .op_sel        (op_sel),
        .btn_ok        (btn_ok),
        .btn_clr       (btn_clr),
        .current_state (current_state),
        .data_saved    (data_saved),
        .err           (err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_state, m_data, m_err, m_a, m_b, m_op, m_left;
    bit m_okq, m_clrq;

    typedef struct {
        int a; int b; int op;
        int exp_data; int exp_err; int exp_state; int exp_cycles;
    } row_t;
    row_t rows[$];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = ST_A; m_data = 0; m_err = 0;
        m_a = 0; m_b = 0; m_op = 0; m_left = 0;
        m_okq = 1'b1; m_clrq = 1'b1;
    endfunction

    function automatic void model_step();
        bit okp, clrp;
        int r;
        okp  = btn_ok && !m_okq;
        clrp = btn_clr && !m_clrq;
        m_okq  = btn_ok;
        m_clrq = btn_clr;
        if (clrp) begin
            m_state = ST_A; m_data = 0; m_err = 0;
        end else if (m_state == ST_A) begin
            if (okp) begin m_a = int'(sw); m_data = m_a; m_state = ST_B; end
        end else if (m_state == ST_B) begin
            if (okp) begin
                m_b = int'(sw); m_op = int'(op_sel); m_state = ST_CALC;
                m_left = (m_op == 3 && DIV_EN && m_b != 0) ? W : 1;
            end
        end else if (m_state == ST_CALC) begin
            m_left--;
            if (m_left == 0) begin
                m_state = ST_RES;
                case (m_op)
                    0: begin r = m_a + m_b; m_data = r % 256; m_err = (r > 255); end
                    1: begin m_data = (m_a - m_b + 256) % 256; m_err = (m_a < m_b); end
                    2: begin r = m_a * m_b; m_data = r % 256; m_err = (r > 255); end
                    default: begin
                        if (!DIV_EN || m_b == 0) begin m_state = ST_ERR; m_err = 1; end
                        else begin m_data = m_a / m_b; m_err = 0; end
                    end
                endcase
            end
        end else if (m_state == ST_RES) begin
            if (okp) begin m_a = m_data; m_err = 0; m_state = ST_B; end
        end else if (m_state == ST_ERR) begin
            if (okp) begin m_state = ST_A; m_data = 0; m_err = 0; end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("state", 32'(current_state), m_state);
        check("data_saved", 32'(data_saved), m_data);
        check("err", 32'(err), m_err);
        check("busy", 32'(busy), int'(m_state == ST_CALC));
    endtask

    task automatic do_reset(input bit hold_ok);
        rst_n = 1'b0; btn_ok = hold_ok; btn_clr = 1'b0; sw = '0; op_sel = '0;
        model_reset();
        @(negedge clk);
        check("rst_state", 32'(current_state), ST_A);
        check("rst_data", 32'(data_saved), 0);
        check("rst_err_busy", {30'd0, err, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_ok(input int v, input int o);
        btn_ok = 1'b0; tick();
        sw = W'(v); op_sel = 2'(o); btn_ok = 1'b1; tick();
        btn_ok = 1'b0;
    endtask

    task automatic press_clr();
        btn_clr = 1'b0; tick();
        btn_clr = 1'b1; tick();
        btn_clr = 1'b0;
    endtask

    // Returns the number of sampled cycles spent with busy high, bounded.
    task automatic wait_calc(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
    endtask

    task automatic run_row(input row_t r);
        int cnt;
        press_clr();
        press_ok(r.a, 0);
        check("capture_a", 32'(data_saved), r.a);
        press_ok(r.b, r.op);
        wait_calc(cnt);
        check("busy_cycles", cnt, r.exp_cycles);
        check("row_data", 32'(data_saved), r.exp_data);
        check("row_err", 32'(err), r.exp_err);
        check("row_state", 32'(current_state), r.exp_state);
    endtask

    initial begin
        int cnt;
        rows.push_back('{8'h12, 8'h34, 0, 8'h46, 0, ST_RES, 1});
        rows.push_back('{8'hF0, 8'h20, 0, 8'h10, 1, ST_RES, 1});
        rows.push_back('{8'h05, 8'h07, 1, 8'hFE, 1, ST_RES, 1});
        rows.push_back('{8'hFF, 8'h01, 1, 8'hFE, 0, ST_RES, 1});
        rows.push_back('{8'h0F, 8'h0F, 2, 8'hE1, 0, ST_RES, 1});
        rows.push_back('{8'h10, 8'h11, 2, 8'h10, 1, ST_RES, 1});
        if (DIV_EN) rows.push_back('{8'hC8, 8'h07, 3, 8'h1C, 0, ST_RES, 8});
        else        rows.push_back('{8'hC8, 8'h07, 3, 8'hC8, 1, ST_ERR, 1});
        rows.push_back('{8'hC8, 8'h00, 3, 8'hC8, 1, ST_ERR, 1});

        do_reset(1'b1);
        repeat (3) tick();
        check("held_ok_state", 32'(current_state), ST_A);
        btn_ok = 1'b0;

        foreach (rows[i]) run_row(rows[i]);

        // ok in S_ERROR returns to input A with cleared outputs
        press_ok(0, 0);
        check("err_exit_state", 32'(current_state), ST_A);
        check("err_exit_data", 32'(data_saved), 0);

        // chaining: result 0x10 becomes operand A
        run_row('{8'h10, 8'h11, 2, 8'h10, 1, ST_RES, 1});
        press_ok(0, 0);
        check("chain_state", 32'(current_state), ST_B);
        check("chain_err", 32'(err), 0);
        press_ok(8'h02, 0);
        wait_calc(cnt);
        check("chain_data", 32'(data_saved), 8'h12);

        if (DIV_EN) begin
            press_clr();
            press_ok(8'hC8, 0);
            press_ok(8'h07, 3);
            repeat (2) tick();
            btn_clr = 1'b1; tick();
            btn_clr = 1'b0;
            check("abort_state", 32'(current_state), ST_A);
            check("abort_data", 32'(data_saved), 0);
            check("abort_busy", 32'(busy), 0);
            repeat (12) tick();
            check("abort_no_result", 32'(data_saved), 0);
        end

        // ok and clr rising together in S_INPUT_B: clear wins
        press_clr();
        press_ok(8'h05, 0);
        tick();
        sw = 8'h09; btn_ok = 1'b1; btn_clr = 1'b1; tick();
        btn_ok = 1'b0; btn_clr = 1'b0;
        check("okclr_state", 32'(current_state), ST_A);

        // asynchronous reset in S_RESULT
        run_row('{8'h12, 8'h34, 0, 8'h46, 0, ST_RES, 1});
        #2 rst_n = 1'b0;
        #1;
        check("async_state", 32'(current_state), ST_A);
        check("async_data", 32'(data_saved), 0);
        check("async_err_busy", {30'd0, err, busy}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 2500; i++) begin
            btn_ok  = ($urandom_range(3) == 0);
            btn_clr = ($urandom_range(39) == 0);
            sw      = ($urandom_range(7) == 0) ? '0 : W'($urandom);
            op_sel  = 2'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Main sequencing FSM of the calculator. It captures operand A and operand B from the switches, latches an operator, runs the arithmetic (multi-cycle for division), and publishes `current_state` and `data_saved` to the LED driver and the display path. It is the single source of the calculator's state encoding.

## Interface
Parameters:
- `W`, 8: operand, result and `data_saved` width.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `sw`  in  W  operand switches, already synchronous to `clk`.
- `op_sel`  in  2  operator: 0 add, 1 sub, 2 mul, 3 div.
- `btn_ok`  in  1  confirm button, synchronized and debounced level.
- `btn_clr`  in  1  clear button, synchronized and debounced level.
- `current_state`  out  3  state code, consumed by the LED driver.
- `data_saved`  out  W  value shown on LEDs: operand A, or the result.
- `err`  out  1  arithmetic overflow, or invalid or illegal operation.
- `busy`  out  1  high while in S_CALC.

## Operation
- Edge detect: `ok_p = btn_ok & ~ok_q` and `clr_p = btn_clr & ~clr_q`. `ok_q` and `clr_q` reset to 1, so a button held through reset release does not produce a pulse.
- State codes: S_INPUT_A=0, S_INPUT_B=1, S_RESULT=2, S_CALC=3, S_ERROR=4. Codes 5–7 are unreachable and recover to S_INPUT_A.
- `clr_p` in any state goes to S_INPUT_A, sets `data_saved`=0 and `err`=0, and aborts any division in progress. `clr_p` has priority over `ok_p` when both occur in the same cycle.
- S_INPUT_A, on `ok_p`: `a`=`sw`, `data_saved`=`sw`, go to S_INPUT_B.
- S_INPUT_B, on `ok_p`: `b`=`sw`, `op`=`op_sel`, go to S_CALC.
- S_CALC, by operator:
  - add: result = (a+b) mod 2^W; `err` = carry out.
  - sub: result = (a−b) mod 2^W; `err` = borrow (a<b).
  - mul: result = low W bits of a·b; `err` = 1 if the high W bits are nonzero.
  - div with b≠0: quotient; `err`=0.
  - div with b=0: go to S_ERROR with `err`=1 and `data_saved` unchanged.
- On completion go to S_RESULT with `data_saved`=result. `ok_p` is ignored while in S_CALC.
- S_RESULT, on `ok_p`: chain the calculation. `a`=result, `err`=0, go to S_INPUT_B; `data_saved` keeps the result.
- S_ERROR, on `ok_p`: go to S_INPUT_A with `data_saved`=0 and `err`=0.
- Reset values: `current_state`=S_INPUT_A, `data_saved`=0, `err`=0, `busy`=0; internal `a`, `b` and `op` are 0.

## Timing
- All outputs are registered. A state change occurs on the first `clk` edge that samples the button high, so the pulse to state update latency is 0 cycles after sampling.
- S_CALC duration: exactly 1 cycle for add, sub, mul and divide-by-zero; exactly W cycles (8) for division with b≠0.
- `busy` equals (`current_state`==S_CALC), cycle-exact.
- Reset asserted during division: all state is cleared immediately (asynchronous), and no result is published after release.

## Configuration
- `CALC_DIV_EN` defined: the divider is instantiated and op 3 performs division as described above.
- `CALC_DIV_EN` undefined: the divider is not instantiated. Op 3 is illegal and goes S_CALC→S_ERROR in 1 cycle with `err`=1. The other operators are unaffected.

## Structure
- `calc_pkg` holds the state code localparams (S_INPUT_A..S_ERROR, 3 bits) and the opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV. Both the LED driver and `calc_ctrl` import it.
- Sub-module `calc_divider` is a restoring divider, one quotient bit per cycle.
  - Inputs: `start` pulse, `dividend`, `divisor`, `abort`.
  - Outputs: `done` pulse, `quotient`.
  - `done` fires W cycles after `start`.
  - It is guarded by `CALC_DIV_EN`.

## Test plan
- A=0x12, B=0x34, add → S_INPUT_B after A is captured with `data_saved`=0x12; then S_CALC for 1 cycle; then S_RESULT with `data_saved`=0x46 and `err`=0.
- A=0xF0, B=0x20, add → `data_saved`=0x10 and `err`=1. A=0x05, B=0x07, sub → `data_saved`=0xFE and `err`=1.
- A=0x10, B=0x11, mul → `data_saved`=0x10 and `err`=1 (product 0x110). Then `ok_p` in S_RESULT → S_INPUT_B with `a`=0x10.
- With `CALC_DIV_EN`: A=0xC8, B=0x07, div → `busy` high for exactly 8 cycles, then `data_saved`=0x1C (28). With B=0 → S_ERROR and `err`=1. Without the macro, op 3 → S_ERROR after 1 cycle.
- `btn_clr` rises at the 4th division cycle → next state is S_INPUT_A with `data_saved`=0 and `busy`=0, and no later result appears. `btn_ok` and `btn_clr` rising in the same cycle in S_INPUT_B → S_INPUT_A.
- Hold `btn_ok` high across reset release → state stays S_INPUT_A. `rst_n` pulsed low during S_RESULT → all outputs return to their reset values immediately.
